// File: rtl/fifo_burst_reader.sv
// Read-domain consumer for an async FIFO: pops words into a 2-entry buffer
// and re-emits them as fixed-length bursts on a valid/ready stream.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  enable,
    input  logic                  fifo_rempty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_cnt,
    output logic [CNT_WIDTH-1:0]  burst_cnt
);

    localparam int BW = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FINISH, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         beat_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] data_q [2];
    logic                  last_q [2];
    logic [CNT_WIDTH-1:0]  word_cnt_q, burst_cnt_q;

    logic can_pop, rd_en_d, beat_at_last, beat_zero, pop, hs;

    assign beat_at_last = (beat_q == BW'(BURST_LEN - 1));
    assign beat_zero    = (beat_q == '0);
    assign can_pop      = !fifo_rempty && (occ_q != 2'd2);
    assign m_valid      = (occ_q != 2'd0);
    assign hs           = m_valid && m_ready;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        rd_en_d = 1'b0;
        case (state_q)
            IDLE: if (enable) state_d = RUN;
            RUN: begin
                if (enable) begin
                    rd_en_d = can_pop;
                end else if (beat_zero) begin
                    state_d = IDLE;
                end else begin
                    rd_en_d = can_pop;
                    state_d = (can_pop && beat_at_last) ? DRAIN : FINISH;
                end
            end
            FINISH: begin
                rd_en_d = can_pop;
                if (can_pop && beat_at_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (occ_q == 2'd0 || (occ_q == 2'd1 && hs))
                    state_d = enable ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Read enable depends only on registered state, enable and the FIFO flag.
    assign fifo_rd_en = !rrst && rd_en_d;
    assign pop        = fifo_rd_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            occ_q       <= 2'd0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            // NOTE: the two buffer slots are reset as well, because m_data must read zero after reset.
            for (int i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                last_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;
            if (pop) beat_q <= beat_at_last ? '0 : beat_q + BW'(1);

            case ({pop, hs})
                2'b10: begin
                    data_q[occ_q[0]] <= fifo_rdata;
                    last_q[occ_q[0]] <= beat_at_last;
                    occ_q            <= occ_q + 2'd1;
                end
                2'b01: begin
                    data_q[0] <= data_q[1];
                    last_q[0] <= last_q[1];
                    occ_q     <= occ_q - 2'd1;
                end
                2'b11: begin
                    // Pop and handshake together only happen with one entry held.
                    data_q[0] <= fifo_rdata;
                    last_q[0] <= beat_at_last;
                end
                default: ;
            endcase

            if (hs) word_cnt_q <= word_cnt_q + CNT_WIDTH'(1);
            if (hs && last_q[0]) burst_cnt_q <= burst_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign m_data    = data_q[0];
    assign m_last    = m_valid && last_q[0];
    assign busy      = (state_q != IDLE) || m_valid;
    assign word_cnt  = word_cnt_q;
    assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a queue-based FIFO and stream model check every
// cycle, plus scenario tasks for bursts, backpressure, stalls, finish and reset.
module tb_fifo_burst_reader;

    logic       rclk = 1'b0;
    logic       rrst = 1'b0;
    logic       enable = 1'b0;
    logic       fifo_rempty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       m_ready = 1'b0;

    logic        a_rd_en, a_valid, a_last, a_busy;
    logic [7:0]  a_data;
    logic [31:0] a_wcnt, a_bcnt;
    logic        b_rd_en, b_valid, b_last, b_busy;
    logic [7:0]  b_data;
    logic [31:0] b_wcnt, b_bcnt;

    bit sel = 1'b0;
    logic        obs_rd_en, obs_valid, obs_last, obs_busy;
    logic [7:0]  obs_data;
    logic [31:0] obs_wcnt, obs_bcnt;

    assign obs_rd_en = sel ? b_rd_en : a_rd_en;
    assign obs_valid = sel ? b_valid : a_valid;
    assign obs_last  = sel ? b_last  : a_last;
    assign obs_busy  = sel ? b_busy  : a_busy;
    assign obs_data  = sel ? b_data  : a_data;
    assign obs_wcnt  = sel ? b_wcnt  : a_wcnt;
    assign obs_bcnt  = sel ? b_bcnt  : a_bcnt;

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(16), .CNT_WIDTH(32)) dut_a (
        .rclk(rclk), .rrst(rrst), .enable(enable), .fifo_rempty(fifo_rempty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(a_rd_en), .m_valid(a_valid),
        .m_ready(m_ready), .m_data(a_data), .m_last(a_last), .busy(a_busy),
        .word_cnt(a_wcnt), .burst_cnt(a_bcnt)
    );

    fifo_burst_reader #(.DATA_WIDTH(8), .BURST_LEN(2), .CNT_WIDTH(32)) dut_b (
        .rclk(rclk), .rrst(rrst), .enable(enable), .fifo_rempty(fifo_rempty),
        .fifo_rdata(fifo_rdata), .fifo_rd_en(b_rd_en), .m_valid(b_valid),
        .m_ready(m_ready), .m_data(b_data), .m_last(b_last), .busy(b_busy),
        .word_cnt(b_wcnt), .burst_cnt(b_bcnt)
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad = 0;
    int bl = 16;
    logic [7:0] fifo_q[$];
    logic [7:0] popped_q[$];
    int emitted = 0;
    int bursts = 0;
    int pops = 0;
    int first_pop = -1;
    int last_pop = -1;
    int cyc = 0;

    task automatic refresh();
        fifo_rempty = (fifo_q.size() == 0);
        fifo_rdata  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    endtask

    task automatic push_words(input int n, input bit rnd, input int base);
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(rnd ? 8'($urandom) : 8'(base + i));
        end
        refresh();
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic step();
        bit pop, hs, exp_last;
        @(negedge rclk);
        exp_last = ((emitted % bl) == bl - 1);
        if (rrst) begin
            total++;
            if (obs_rd_en !== 1'b0) begin
                bad++; $display("FAIL rd_en_in_reset: got %b expected 0", obs_rd_en);
            end
        end else begin
            total++;
            if (obs_valid !== (popped_q.size() != 0)) begin
                bad++; $display("FAIL m_valid: got %b expected %0b (cycle %0d)", obs_valid, popped_q.size() != 0, cyc);
            end
            if (popped_q.size() != 0) begin
                total += 3;
                if (obs_data !== popped_q[0]) begin
                    bad++; $display("FAIL m_data: got %h expected %h (cycle %0d)", obs_data, popped_q[0], cyc);
                end
                if (obs_last !== exp_last) begin
                    bad++; $display("FAIL m_last: got %b expected %b (word %0d)", obs_last, exp_last, emitted);
                end
                if (obs_busy !== 1'b1) begin
                    bad++; $display("FAIL busy_with_data: got %b expected 1", obs_busy);
                end
            end else begin
                total++;
                if (obs_last !== 1'b0) begin
                    bad++; $display("FAIL m_last_idle: got %b expected 0", obs_last);
                end
            end
            total++;
            if ($isunknown(obs_rd_en) || (obs_rd_en && (fifo_rempty || popped_q.size() >= 2))) begin
                bad++; $display("FAIL rd_en: got %b expected 0 (empty=%b held=%0d)", obs_rd_en, fifo_rempty, popped_q.size());
            end
            total += 2;
            if (obs_wcnt !== 32'(emitted)) begin
                bad++; $display("FAIL word_cnt: got %0d expected %0d", obs_wcnt, emitted);
            end
            if (obs_bcnt !== 32'(bursts)) begin
                bad++; $display("FAIL burst_cnt: got %0d expected %0d", obs_bcnt, bursts);
            end
        end
        pop = !rrst && (obs_rd_en === 1'b1) && !fifo_rempty;
        hs  = !rrst && (obs_valid === 1'b1) && m_ready;
        @(posedge rclk);
        #1;
        cyc++;
        if (rrst) begin
            popped_q.delete();
            emitted = 0;
            bursts  = 0;
        end else begin
            if (hs && popped_q.size() != 0) begin
                void'(popped_q.pop_front());
                if (exp_last) bursts++;
                emitted++;
            end
            if (pop) begin
                popped_q.push_back(fifo_q.pop_front());
                pops++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
            end
        end
        refresh();
    endtask

    task automatic clear_stats();
        pops = 0; first_pop = -1; last_pop = -1;
    endtask

    task automatic do_reset();
        fifo_q.delete();
        refresh();
        rrst = 1'b1; enable = 1'b0; m_ready = 1'b0;
        step(); step();
        rrst = 1'b0;
        clear_stats();
    endtask

    task automatic run_emitted(input int n, input int budget, input bit rnd_ready, input string name);
        int k = 0;
        while (emitted < n && k < budget) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            step(); k++;
        end
        total++;
        if (emitted < n) begin
            bad++; $display("FAIL %s_timeout: emitted %0d expected %0d", name, emitted, n);
        end
    endtask

    task automatic run_pops(input int n, input int budget, input bit rnd_ready, input string name);
        int k = 0;
        while (pops < n && k < budget) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            step(); k++;
        end
        total++;
        if (pops < n) begin
            bad++; $display("FAIL %s_timeout: pops %0d expected %0d", name, pops, n);
        end
    endtask

    task automatic run_idle(input int budget, input bit rnd_ready, input string name);
        int k = 0;
        while (obs_busy !== 1'b0 && k < budget) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            step(); k++;
        end
        total++;
        if (obs_busy !== 1'b0) begin
            bad++; $display("FAIL %s_timeout: busy %b expected 0", name, obs_busy);
        end
    endtask

    task automatic test_reset();
        fifo_q.delete();
        push_words(16, 1'b0, 0);
        rrst = 1'b1; enable = 1'b1; m_ready = 1'b1;
        step(); step();
        total += 6;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b expected 0", obs_valid); end
        if (obs_last  !== 1'b0) begin bad++; $display("FAIL reset_last: got %b expected 0", obs_last); end
        if (obs_data  !== 8'h00) begin bad++; $display("FAIL reset_data: got %h expected 00", obs_data); end
        if (obs_busy  !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", obs_busy); end
        if (obs_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b expected 0", obs_rd_en); end
        if (obs_wcnt !== 32'd0 || obs_bcnt !== 32'd0) begin
            bad++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", obs_wcnt, obs_bcnt);
        end
        rrst = 1'b0;
        clear_stats();
    endtask

    task automatic test_full_burst();
        run_emitted(16, 60, 1'b0, "full_burst");
        total += 3;
        if (pops != 16 || last_pop - first_pop != 15) begin
            bad++; $display("FAIL full_burst_pops: got %0d pops over %0d cycles expected 16 over 15", pops, last_pop - first_pop);
        end
        if (obs_wcnt !== 32'd16) begin bad++; $display("FAIL full_burst_wcnt: got %0d expected 16", obs_wcnt); end
        if (obs_bcnt !== 32'd1) begin bad++; $display("FAIL full_burst_bcnt: got %0d expected 1", obs_bcnt); end
        enable = 1'b0;
        run_idle(20, 1'b0, "full_burst_idle");
    endtask

    task automatic test_backpressure();
        logic [7:0] w0;
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        push_words(4, 1'b1, 0);
        w0 = fifo_q[0];
        repeat (10) step();
        total += 3;
        if (pops != 2) begin bad++; $display("FAIL bp_pops: got %0d expected 2", pops); end
        if (obs_rd_en !== 1'b0) begin bad++; $display("FAIL bp_rd_en: got %b expected 0", obs_rd_en); end
        if (obs_data !== w0) begin bad++; $display("FAIL bp_hold: got %h expected %h", obs_data, w0); end
        m_ready = 1'b1;
        run_emitted(4, 30, 1'b0, "bp_release");
        total++;
        if (fifo_q.size() != 0 || pops != 4) begin
            bad++; $display("FAIL bp_drain: got %0d pops, %0d left expected 4, 0", pops, fifo_q.size());
        end
    endtask

    task automatic test_empty_stall();
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        push_words(5, 1'b1, 0);
        run_emitted(5, 20, 1'b0, "stall_first");
        repeat (20) begin m_ready = 1'($urandom_range(0, 1)); step(); end
        total += 2;
        if (pops != 5) begin bad++; $display("FAIL stall_pops: got %0d expected 5", pops); end
        if (obs_rd_en !== 1'b0) begin bad++; $display("FAIL stall_rd_en: got %b expected 0", obs_rd_en); end
        push_words(11, 1'b1, 0);
        run_emitted(16, 120, 1'b1, "stall_rest");
        total++;
        if (obs_bcnt !== 32'd1) begin bad++; $display("FAIL stall_bcnt: got %0d expected 1", obs_bcnt); end
    endtask

    task automatic test_finish();
        do_reset();
        enable = 1'b1;
        push_words(40, 1'b1, 0);
        run_pops(8, 100, 1'b1, "finish_start");
        enable = 1'b0;
        run_idle(300, 1'b1, "finish_drain");
        total += 3;
        if (pops != 16) begin bad++; $display("FAIL finish_pops: got %0d expected 16", pops); end
        if (fifo_q.size() != 24) begin bad++; $display("FAIL finish_left: got %0d expected 24", fifo_q.size()); end
        if (obs_bcnt !== 32'd1 || obs_wcnt !== 32'd16) begin
            bad++; $display("FAIL finish_cnt: got %0d/%0d expected 16/1", obs_wcnt, obs_bcnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1; m_ready = 1'b0;
        push_words(10, 1'b0, 8'h40);
        repeat (5) step();
        total++;
        if (obs_valid !== 1'b1 || pops != 2) begin
            bad++; $display("FAIL mid_fill: got valid %b pops %0d expected 1, 2", obs_valid, pops);
        end
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        total += 3;
        if (obs_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b expected 0", obs_valid); end
        if (obs_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b expected 0", obs_rd_en); end
        if (obs_wcnt !== 32'd0 || obs_bcnt !== 32'd0) begin
            bad++; $display("FAIL mid_cnt: got %0d/%0d expected 0/0", obs_wcnt, obs_bcnt);
        end
        m_ready = 1'b1;
        push_words(16, 1'b1, 0);
        run_emitted(16, 120, 1'b1, "mid_after");
        total++;
        if (obs_bcnt !== 32'd1) begin bad++; $display("FAIL mid_bcnt: got %0d expected 1", obs_bcnt); end
    endtask

    task automatic test_burst2();
        int k = 0;
        sel = 1'b1; bl = 2;
        do_reset();
        enable = 1'b1;
        push_words(6, 1'b0, 8'hA0);
        while (emitted < 6 && k < 60) begin
            m_ready = ~m_ready;
            step(); k++;
        end
        total += 3;
        if (emitted < 6) begin bad++; $display("FAIL b2_timeout: emitted %0d expected 6", emitted); end
        if (obs_bcnt !== 32'd3) begin bad++; $display("FAIL b2_bcnt: got %0d expected 3", obs_bcnt); end
        if (obs_wcnt !== 32'd6) begin bad++; $display("FAIL b2_wcnt: got %0d expected 6", obs_wcnt); end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_backpressure();
        test_empty_stall();
        test_finish();
        test_reset_mid();
        test_burst2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side consumer for the asynchronous FIFO, running entirely in the read clock domain.
- Pops words through the FIFO read port (read enable, empty flag, combinational read data) and re-emits them on a valid/ready stream.
- Groups the output into fixed-length bursts tagged with a last flag.
- A 2-entry output buffer decouples FIFO pops from downstream backpressure; enable control stops reading only on a burst boundary.

Parameters:
- DATA_WIDTH, 8, FIFO word width.
- BURST_LEN, 16, words per burst, >=2.
- CNT_WIDTH, 32, width of the total-word and burst statistics counters.

Ports:
- rclk  input  1  read-domain clock; all logic on its rising edge.
- rrst  input  1  synchronous active-high reset.
- enable  input  1  level; 1 = start or continue bursts.
- fifo_rempty  input  1  FIFO registered empty flag.
- fifo_rdata  input  DATA_WIDTH  FIFO combinational read data (word at the current read pointer).
- fifo_rd_en  output  1  FIFO read enable.
- m_valid  output  1  output word valid.
- m_ready  input  1  downstream accepts word.
- m_data  output  DATA_WIDTH  output word.
- m_last  output  1  final word of a burst.
- busy  output  1  state != IDLE or buffer non-empty.
- word_cnt  output  CNT_WIDTH  total words emitted (output handshakes).
- burst_cnt  output  CNT_WIDTH  bursts completed (handshakes with m_last=1).

Behaviour:
- Reset (rrst=1 at edge):
  - State IDLE; buffer emptied; beat index 0; word_cnt=0; burst_cnt=0.
  - Outputs m_valid=0, m_last=0, m_data=0, busy=0.
  - fifo_rd_en is forced 0 combinationally while rrst=1.
  - Reset mid-burst discards buffered words; no partial burst is completed.
- Pop:
  - A pop occurs at an edge where fifo_rd_en=1 and fifo_rempty=0.
  - The popped word is fifo_rdata sampled at that same edge and is written to the buffer tail on that edge.
- Read enable: fifo_rd_en = !rrst && state in {RUN, FINISH} && !fifo_rempty && occupancy<2.
  - occupancy is the registered buffer count.
  - fifo_rd_en has no combinational path from m_ready.
- Buffer:
  - 2-entry FIFO with occupancy 0..2; the head drives m_data/m_last; m_valid = occupancy!=0.
  - A pop and an output handshake in the same cycle leave occupancy unchanged.
  - Read-side latency is 1 cycle: the popped word is visible on m_data the cycle after the pop edge when the buffer was empty.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
- Last tagging:
  - A beat index 0..BURST_LEN-1 increments on each pop.
  - The popped word is tagged last when the index is BURST_LEN-1; the index then wraps to 0.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 and beat index=0; no pop is issued in that cycle.
  - RUN -> FINISH when enable=0 and beat index!=0.
  - FINISH keeps popping until the last-tagged word is popped, then -> DRAIN. enable is ignored in FINISH.
  - DRAIN issues no pops.
  - DRAIN -> IDLE when occupancy=0, or becomes 0 this cycle.
  - DRAIN -> RUN instead if enable=1 at that point.
- FIFO empty mid-burst: pops stall and the beat index holds; there is no timeout and the burst never terminates early.
- Counters:
  - word_cnt increments on each m_valid && m_ready.
  - burst_cnt increments on handshakes with m_last=1.
  - Both wrap modulo 2^CNT_WIDTH.

Test Plan:
- Reset, then enable=1, FIFO preloaded with 16 words 0x00..0x0F, m_ready=1 -> 16 pops on consecutive cycles; m_data 0x00..0x0F in order; m_last only on 0x0F; word_cnt=16, burst_cnt=1.
- Backpressure: 4 words queued, m_ready=0 -> exactly 2 pops, then fifo_rd_en=0 and m_data held at word 0. Release m_ready -> words 0..3 delivered in order with no loss or duplication.
- FIFO empties after 5 words of a burst, then 11 more words arrive 20 cycles later -> fifo_rd_en=0 while fifo_rempty=1; m_last only on the 16th word.
- enable dropped after word 7 of a burst, 40 words available -> state FINISH; reader stops after word 15 with m_last=1; busy falls once the buffer drains; 24 words remain in the FIFO.
- rrst asserted for 1 cycle with occupancy=2 mid-burst -> next cycle m_valid=0, fifo_rd_en=0, counters 0; a later burst starts with beat index 0 (m_last on its 16th word).
- BURST_LEN=2, 6 words, m_ready toggling 1/0 each cycle -> m_last on words 1, 3 and 5; burst_cnt=3; word_cnt=6.
